// File: rtl/stream_divider_pkg.sv
// Shared types and constants for the stream divider: FSM state encoding,
// default operand widths and the step-counter width helper.
package stream_divider_pkg;

  localparam int DEF_DIVIDEND_W = 32;
  localparam int DEF_DIVISOR_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // One spare bit so the counter can hold DIVIDEND_W without wrapping.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/stream_divider_if.sv
// Operand/result stream bundle for the divider: valid/ready on the input,
// valid-only on the output.
interface stream_divider_if #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 16
);

  logic                  i_ready;
  logic                  i_valid;
  logic [DIVIDEND_W-1:0] i_payload_dividend;
  logic [DIVISOR_W-1:0]  i_payload_divisor;
  logic                  o_valid;
  logic [DIVIDEND_W-1:0] o_payload_quotient;
  logic [DIVISOR_W-1:0]  o_payload_remainder;
  logic                  o_payload_dbz;

  modport master (
    input  i_ready,
    output i_valid,
    output i_payload_dividend,
    output i_payload_divisor,
    input  o_valid,
    input  o_payload_quotient,
    input  o_payload_remainder,
    input  o_payload_dbz
  );

  modport slave (
    output i_ready,
    input  i_valid,
    input  i_payload_dividend,
    input  i_payload_divisor,
    output o_valid,
    output o_payload_quotient,
    output o_payload_remainder,
    output o_payload_dbz
  );

endinterface

// File: rtl/stream_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference when it did not borrow.
module div_step #(
  parameter int DIVISOR_W = 16
) (
  input  logic [DIVISOR_W:0]   rem,
  input  logic                 next_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   rem_next,
  output logic                 quo_bit
);

  logic [DIVISOR_W:0]   shifted;
  logic [DIVISOR_W+1:0] trial;

  // A set rem MSB means the true shifted value exceeds any divisor, so the
  // subtraction is always valid then; the low bits of trial are still exact.
  always_comb begin
    shifted  = {rem[DIVISOR_W-1:0], next_bit};
    trial    = {1'b0, shifted} - {2'b00, divisor};
    quo_bit  = ~trial[DIVISOR_W+1] | rem[DIVISOR_W];
    rem_next = quo_bit ? trial[DIVISOR_W:0] : shifted;
  end

endmodule

// File: rtl/stream_divider.sv
// Iterative unsigned divider: accepts a dividend/divisor pair, produces one
// quotient bit per cycle and emits quotient, remainder and divide-by-zero.
module stream_divider
  import stream_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic             clk,
  input  logic             reset,
  stream_divider_if.slave  bus
);

  localparam int CNT_W = cnt_width(DIVIDEND_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

  state_t                state;
  logic [CNT_W-1:0]      count;
  logic [DIVIDEND_W-1:0] quo_q;
  logic [DIVISOR_W:0]    rem_q;
  logic [DIVISOR_W-1:0]  divisor_q;
  logic                  dbz_q;

  logic                  valid_q;
  logic [DIVIDEND_W-1:0] quotient_q;
  logic [DIVISOR_W-1:0]  remainder_q;
  logic                  dbz_out_q;

  logic [DIVISOR_W:0]    rem_next;
  logic                  quo_bit;

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .rem      (rem_q),
    .next_bit (quo_q[DIVIDEND_W-1]),
    .divisor  (divisor_q),
    .rem_next (rem_next),
    .quo_bit  (quo_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      divisor_q   <= '0;
      dbz_q       <= 1'b0;
      valid_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_out_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_q <= 1'b0;
          if (bus.i_valid) begin
            quo_q     <= bus.i_payload_dividend;
            divisor_q <= bus.i_payload_divisor;
            rem_q     <= '0;
            count     <= '0;
            dbz_q     <= (bus.i_payload_divisor == '0);
            state     <= BUSY;
          end
        end
        BUSY: begin
          quo_q <= {quo_q[DIVIDEND_W-2:0], quo_bit};
          rem_q <= rem_next;
          count <= count + 1'b1;
          // Result registers load on the last step so they change only on DONE entry.
          if (count == LAST_STEP) begin
            state       <= DONE;
            valid_q     <= 1'b1;
            quotient_q  <= {quo_q[DIVIDEND_W-2:0], quo_bit};
            remainder_q <= rem_next[DIVISOR_W-1:0];
            dbz_out_q   <= dbz_q;
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.i_ready             = (state == IDLE);
  assign bus.o_valid             = valid_q;
  assign bus.o_payload_quotient  = quotient_q;
  assign bus.o_payload_remainder = remainder_q;
  assign bus.o_payload_dbz       = dbz_out_q;

endmodule

// File: tb/tb_stream_divider.sv
// Self-checking bench for stream_divider: scoreboard of expected results
// pushed at each accepted handshake and popped when o_valid fires.
module tb_stream_divider;

  localparam int DW = 32;
  localparam int VW = 16;

  typedef struct {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dbz;
    int            accept_edge;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cycle = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  stream_divider_if #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) bus ();

  stream_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Reference result computed with ordinary integer arithmetic.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b, input int e);
    exp_t x;
    if (b == '0) begin
      x.q   = '1;
      x.r   = a[VW-1:0];
      x.dbz = 1'b1;
    end else begin
      x.q   = a / DW'(b);
      x.r   = VW'(a % DW'(b));
      x.dbz = 1'b0;
    end
    x.accept_edge = e;
    return x;
  endfunction

  // Offer one pair and hold it until the handshake edge, then drop i_valid.
  task automatic send_pair(input logic [DW-1:0] a, input logic [VW-1:0] b, output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    bus.i_valid            = 1'b1;
    bus.i_payload_dividend = a;
    bus.i_payload_divisor  = b;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.i_ready === 1'b1) begin
        sb.push_back(model(a, b, cycle + 1));
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_result(output bit got, output int at, output logic [DW-1:0] q,
                             output logic [VW-1:0] r, output logic d);
    got = 1'b0; at = 0; q = '0; r = '0; d = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.o_valid === 1'b1) begin
        got = 1'b1;
        at  = cycle;
        q   = bus.o_payload_quotient;
        r   = bus.o_payload_remainder;
        d   = bus.o_payload_dbz;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.i_valid            = 1'b1;
    bus.i_payload_dividend = 32'd100;
    bus.i_payload_divisor  = 16'd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_o_valid: got %b expected 0", bus.o_valid); end
    @(posedge clk); #1;
    reset       = 1'b0;
    bus.i_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.i_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_i_ready: got %b expected 1", bus.i_ready); end
    checks++;
    if (bus.o_payload_quotient !== '0) begin failures++; $display("[TB] FAIL reset_quotient: got %h expected 0", bus.o_payload_quotient); end
    checks++;
    if (bus.o_payload_remainder !== '0 || bus.o_payload_dbz !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_rem_dbz: got %h/%b expected 0/0", bus.o_payload_remainder, bus.o_payload_dbz);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.i_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_no_accept: i_ready got %b expected 1", bus.i_ready); end
  endtask

  task automatic test_basic;
    bit ok, got; int at; logic [DW-1:0] q; logic [VW-1:0] r; logic d; exp_t e;
    send_pair(32'd100, 16'd7, ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL basic_accept: got no handshake expected one"); end
    wait_result(got, at, q, r, d);
    checks++;
    if (!got || sb.size() == 0) begin
      failures++; $display("[TB] FAIL basic_result: got no o_valid expected one");
    end else begin
      e = sb.pop_front();
      checks++;
      if (q !== e.q) begin failures++; $display("[TB] FAIL basic_quotient: got %0d expected %0d", q, e.q); end
      checks++;
      if (r !== e.r || d !== e.dbz) begin failures++; $display("[TB] FAIL basic_rem_dbz: got %0d/%b expected %0d/%b", r, d, e.r, e.dbz); end
      checks++;
      if (at - e.accept_edge !== 32) begin failures++; $display("[TB] FAIL basic_latency: got %0d expected 32", at - e.accept_edge); end
      @(negedge clk);
      checks++;
      if (bus.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_pulse: o_valid got %b expected 0", bus.o_valid); end
      checks++;
      if (bus.o_payload_quotient !== e.q || bus.i_ready !== 1'b1) begin
        failures++; $display("[TB] FAIL basic_hold: quotient/i_ready got %0d/%b expected %0d/1", bus.o_payload_quotient, bus.i_ready, e.q);
      end
    end
    sb.delete();
  endtask

  task automatic test_boundaries;
    logic [DW-1:0] as [8];
    logic [VW-1:0] bs [8];
    bit ok, got; int at; logic [DW-1:0] q; logic [VW-1:0] r; logic d; exp_t e;
    as[0] = 32'hFFFF_FFFF; bs[0] = 16'hFFFF;
    as[1] = 32'd5;         bs[1] = 16'd9;
    as[2] = 32'h1234_5678; bs[2] = 16'd0;
    as[3] = 32'd0;         bs[3] = 16'd0;
    as[4] = 32'hFFFF_FFFF; bs[4] = 16'd1;
    for (int i = 5; i < 8; i++) begin
      as[i] = $urandom;
      bs[i] = 16'($urandom_range(1, 65535));
    end
    for (int i = 0; i < 8; i++) begin
      send_pair(as[i], bs[i], ok);
      wait_result(got, at, q, r, d);
      checks++;
      if (!ok || !got || sb.size() == 0) begin
        failures++; $display("[TB] FAIL bound_%0d_result: got accept=%b valid=%b expected 1/1", i, ok, got);
      end else begin
        e = sb.pop_front();
        checks++;
        if (q !== e.q || r !== e.r || d !== e.dbz) begin
          failures++;
          $display("[TB] FAIL bound_%0d_value: %h/%h got q=%h r=%h dbz=%b expected q=%h r=%h dbz=%b", i, as[i], bs[i], q, r, d, e.q, e.r, e.dbz);
        end
        checks++;
        if (at - e.accept_edge !== 32) begin failures++; $display("[TB] FAIL bound_%0d_latency: got %0d expected 32", i, at - e.accept_edge); end
      end
      sb.delete();
    end
  endtask

  task automatic test_back_to_back;
    int results = 0;
    int last_accept = -1000;
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    exp_t e;
    @(posedge clk); #1;
    a = $urandom; b = 16'($urandom_range(0, 65535));
    bus.i_valid = 1'b1; bus.i_payload_dividend = a; bus.i_payload_divisor = b;
    for (int i = 0; i < 200 && results < 3; i++) begin
      @(negedge clk);
      if (cycle >= last_accept && cycle <= last_accept + 32) begin
        checks++;
        if (bus.i_ready !== 1'b0) begin failures++; $display("[TB] FAIL b2b_busy_ready: cycle %0d got %b expected 0", cycle, bus.i_ready); end
      end else if (cycle == last_accept + 33) begin
        checks++;
        if (bus.i_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_idle_ready: cycle %0d got %b expected 1", cycle, bus.i_ready); end
      end
      if (bus.i_ready === 1'b1) begin
        sb.push_back(model(a, b, cycle + 1));
        last_accept = cycle + 1;
      end
      if (bus.o_valid === 1'b1) begin
        results++;
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("[TB] FAIL b2b_spurious: got o_valid expected none");
        end else begin
          e = sb.pop_front();
          if (bus.o_payload_quotient !== e.q || bus.o_payload_remainder !== e.r || bus.o_payload_dbz !== e.dbz ||
              cycle - e.accept_edge !== 32) begin
            failures++;
            $display("[TB] FAIL b2b_result_%0d: got q=%h r=%h dbz=%b lat=%0d expected q=%h r=%h dbz=%b lat=32", results,
                     bus.o_payload_quotient, bus.o_payload_remainder, bus.o_payload_dbz, cycle - e.accept_edge, e.q, e.r, e.dbz);
          end
        end
      end
      @(posedge clk); #1;
      a = $urandom; b = 16'($urandom_range(0, 65535));
      bus.i_payload_dividend = a; bus.i_payload_divisor = b;
    end
    bus.i_valid = 1'b0;
    checks++;
    if (results !== 3 || sb.size() != 0) begin
      failures++; $display("[TB] FAIL b2b_count: got %0d results, %0d pending expected 3, 0", results, sb.size());
    end
    sb.delete();
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_mid;
    bit ok, got; int at; logic [DW-1:0] q; logic [VW-1:0] r; logic d; exp_t e;
    int seen = 0;
    send_pair(32'hDEAD_BEEF, 16'h1234, ok);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if (bus.i_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL midreset_ctrl: i_ready/o_valid got %b/%b expected 1/0", bus.i_ready, bus.o_valid);
    end
    checks++;
    if (bus.o_payload_quotient !== '0 || bus.o_payload_remainder !== '0 || bus.o_payload_dbz !== 1'b0) begin
      failures++; $display("[TB] FAIL midreset_outputs: got %h/%h/%b expected 0/0/0", bus.o_payload_quotient, bus.o_payload_remainder, bus.o_payload_dbz);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.o_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("[TB] FAIL midreset_abandon: got %0d o_valid pulses expected 0", seen); end
    send_pair(32'd1000, 16'd3, ok);
    wait_result(got, at, q, r, d);
    checks++;
    if (!ok || !got || sb.size() == 0) begin
      failures++; $display("[TB] FAIL midreset_followup: got accept=%b valid=%b expected 1/1", ok, got);
    end else begin
      e = sb.pop_front();
      if (q !== e.q || r !== e.r || d !== e.dbz || at - e.accept_edge !== 32) begin
        failures++; $display("[TB] FAIL midreset_followup_value: got %0d r %0d dbz %b lat %0d expected %0d r %0d dbz %b lat 32",
                             q, r, d, at - e.accept_edge, e.q, e.r, e.dbz);
      end
    end
    sb.delete();
  endtask

  initial begin
    bus.i_valid            = 1'b0;
    bus.i_payload_dividend = '0;
    bus.i_payload_divisor  = '0;
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
